// File: rtl/movement_pkg.sv
// Shared types and constants for the line-following movement controller.
package movement_pkg;

  // Track-geometry states; OFF must encode as zero so reset lands there.
  typedef enum logic [3:0] {
    OFF   = 4'd0,
    ST    = 4'd1,
    CL    = 4'd2,
    CR    = 4'd3,
    L90   = 4'd4,
    R90   = 4'd5,
    CROSS = 4'd6,
    C90   = 4'd7,
    CST   = 4'd8
  } state_t;

  // Motor command codes understood by the PWM generators.
  localparam logic [1:0] DRV_STOP = 2'b00;
  localparam logic [1:0] DRV_HALF = 2'b01;
  localparam logic [1:0] DRV_FULL = 2'b10;
  localparam logic [1:0] DRV_REV  = 2'b11;

endpackage

// File: rtl/movement_drive_decode.sv
// Maps a track-geometry state onto the left/right motor commands.
module movement_drive_decode
  import movement_pkg::*;
(
  input  state_t     state,
  output logic [1:0] drive_a,
  output logic [1:0] drive_b
);

  // Pure Moore decode: each state owns one fixed pair of motor commands.
  always_comb begin
    drive_a = DRV_STOP;
    drive_b = DRV_STOP;
    case (state)
      OFF: begin
        drive_a = DRV_STOP;
        drive_b = DRV_STOP;
      end
      ST, CROSS, CST: begin
        drive_a = DRV_FULL;
        drive_b = DRV_FULL;
      end
      CL: begin
        drive_a = DRV_HALF;
        drive_b = DRV_FULL;
      end
      CR: begin
        drive_a = DRV_FULL;
        drive_b = DRV_HALF;
      end
      L90: begin
        drive_a = DRV_REV;
        drive_b = DRV_FULL;
      end
      R90, C90: begin
        drive_a = DRV_FULL;
        drive_b = DRV_REV;
      end
      default: begin
        drive_a = DRV_STOP;
        drive_b = DRV_STOP;
      end
    endcase
  end

endmodule

// File: rtl/movement.sv
// Line-following movement controller: three IR sensors in, two motor
// commands out. The drive outputs are registered from the pre-edge state,
// so they trail the state machine by one cycle.
module movement
  import movement_pkg::*;
(
  input  logic       ACLK,
  input  logic       RST,
  input  logic       IPS_L,
  input  logic       IPS_C,
  input  logic       IPS_R,
  output logic [1:0] DriveA,
  output logic [1:0] DriveB
);

  state_t     state;
  state_t     state_next;
  logic       cross_reg;
  logic       cross_next;
  logic [2:0] sensors;
  logic [1:0] decode_a;
  logic [1:0] decode_b;

  assign sensors = {IPS_L, IPS_C, IPS_R};

  // Next-state selection from current geometry and the LCR sensor pattern.
  always_comb begin
    state_next = state;
    case (state)
      OFF: state_next = ST;
      ST: begin
        case (sensors)
          3'b100, 3'b110: state_next = CL;
          3'b001, 3'b011: state_next = CR;
          3'b101, 3'b111: state_next = CROSS;
          default:        state_next = state;
        endcase
      end
      CL: begin
        case (sensors)
          3'b110:         state_next = L90;
          3'b101, 3'b111: state_next = CROSS;
          3'b001, 3'b011: state_next = CR;
          3'b000, 3'b010: state_next = ST;
          default:        state_next = state;
        endcase
      end
      CR: begin
        case (sensors)
          3'b011:         state_next = R90;
          3'b101, 3'b111: state_next = CROSS;
          3'b100, 3'b110: state_next = CL;
          3'b000, 3'b010: state_next = ST;
          default:        state_next = state;
        endcase
      end
      L90: state_next = (sensors == 3'b110) ? L90 : CL;
      R90: state_next = (sensors == 3'b011) ? R90 : CR;
      CROSS: begin
        case (sensors)
          3'b111:  state_next = C90;
          3'b101:  state_next = cross_reg ? CST : CROSS;
          default: state_next = ST;
        endcase
      end
      C90: state_next = (sensors == 3'b111) ? C90 : R90;
      CST: state_next = (sensors == 3'b101) ? CST : ST;
      default: state_next = OFF;
    endcase
  end

  // Crossover memory: set while turning 90 at a cross, cleared while driving straight through.
  always_comb begin
    cross_next = cross_reg;
    case (state)
      C90:     cross_next = 1'b1;
      CST:     cross_next = 1'b0;
      default: cross_next = cross_reg;
    endcase
  end

  // State and crossover-memory register.
  always_ff @(posedge ACLK or posedge RST) begin
    if (RST) begin
      state     <= OFF;
      cross_reg <= 1'b0;
    end else begin
      state     <= state_next;
      cross_reg <= cross_next;
    end
  end

  movement_drive_decode u_decode (
    .state   (state),
    .drive_a (decode_a),
    .drive_b (decode_b)
  );

  // Drive outputs capture the decode of the state held before this edge.
  always_ff @(posedge ACLK or posedge RST) begin
    if (RST) begin
      DriveA <= DRV_STOP;
      DriveB <= DRV_STOP;
    end else begin
      DriveA <= decode_a;
      DriveB <= decode_b;
    end
  end

endmodule

// File: tb/tb_movement.sv
// Directed, table-driven bench for the movement controller.
module tb_movement;

  logic       clk;
  logic       rst;
  logic       ips_l;
  logic       ips_c;
  logic       ips_r;
  logic [1:0] drive_a;
  logic [1:0] drive_b;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [2:0] sens;
    logic [1:0] exp_a;
    logic [1:0] exp_b;
  } vec_t;

  vec_t vecs[$];

  movement dut (
    .ACLK   (clk),
    .RST    (rst),
    .IPS_L  (ips_l),
    .IPS_C  (ips_c),
    .IPS_R  (ips_r),
    .DriveA (drive_a),
    .DriveB (drive_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add_vec(input logic [2:0] sens, input logic [1:0] ea, input logic [1:0] eb);
    vec_t v;
    v.sens  = sens;
    v.exp_a = ea;
    v.exp_b = eb;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [1:0] ea, input logic [1:0] eb);
    tests_run++;
    if (drive_a !== ea || drive_b !== eb) begin
      tests_failed++;
      $display("[TB] FAIL %s: DriveA/DriveB got %b/%b, expected %b/%b", name, drive_a, drive_b, ea, eb);
    end
  endtask

  // Present a sensor pattern, let one rising edge pass, sample 1 ns later.
  task automatic applyStimulus(input logic [2:0] sens);
    {ips_l, ips_c, ips_r} = sens;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    // Expected drive after each edge is the decode of the state before that edge.
    add_vec(3'b000, 2'b00, 2'b00);
    for (int i = 0; i < 9; i++) add_vec(3'b000, 2'b10, 2'b10);
    add_vec(3'b100, 2'b10, 2'b10);
    add_vec(3'b000, 2'b01, 2'b10);
    add_vec(3'b001, 2'b10, 2'b10);
    add_vec(3'b011, 2'b10, 2'b01);
    add_vec(3'b000, 2'b10, 2'b11);
    add_vec(3'b000, 2'b10, 2'b01);
    add_vec(3'b000, 2'b10, 2'b10);
    for (int i = 0; i < 5; i++) add_vec(3'b101, 2'b10, 2'b10);
    add_vec(3'b111, 2'b10, 2'b10);
    add_vec(3'b000, 2'b10, 2'b11);
    add_vec(3'b000, 2'b10, 2'b11);
    add_vec(3'b000, 2'b10, 2'b01);
    add_vec(3'b000, 2'b10, 2'b10);
    add_vec(3'b110, 2'b10, 2'b10);
    add_vec(3'b110, 2'b01, 2'b10);
    add_vec(3'b110, 2'b11, 2'b10);
    add_vec(3'b101, 2'b11, 2'b10);
    add_vec(3'b101, 2'b01, 2'b10);
    add_vec(3'b101, 2'b10, 2'b10);
    add_vec(3'b101, 2'b10, 2'b10);
    add_vec(3'b000, 2'b10, 2'b10);
    add_vec(3'b000, 2'b10, 2'b10);
    add_vec(3'b101, 2'b10, 2'b10);
    add_vec(3'b101, 2'b10, 2'b10);
    add_vec(3'b111, 2'b10, 2'b10);
    add_vec(3'b000, 2'b10, 2'b11);
    add_vec(3'b000, 2'b10, 2'b11);
    add_vec(3'b000, 2'b10, 2'b01);
    add_vec(3'b000, 2'b10, 2'b10);
    add_vec(3'b010, 2'b10, 2'b10);
    add_vec(3'b100, 2'b10, 2'b10);
    add_vec(3'b100, 2'b01, 2'b10);
    add_vec(3'b100, 2'b01, 2'b10);
    add_vec(3'b001, 2'b01, 2'b10);
    add_vec(3'b001, 2'b10, 2'b01);
    add_vec(3'b010, 2'b10, 2'b01);
    add_vec(3'b000, 2'b10, 2'b10);
    add_vec(3'b110, 2'b10, 2'b10);
    add_vec(3'b011, 2'b01, 2'b10);
    add_vec(3'b110, 2'b10, 2'b01);
    add_vec(3'b111, 2'b01, 2'b10);
    add_vec(3'b100, 2'b10, 2'b10);
    add_vec(3'b000, 2'b10, 2'b10);
    add_vec(3'b011, 2'b10, 2'b10);
    add_vec(3'b111, 2'b10, 2'b01);
    add_vec(3'b010, 2'b10, 2'b10);
    add_vec(3'b000, 2'b10, 2'b10);
    add_vec(3'b111, 2'b10, 2'b10);
    add_vec(3'b111, 2'b10, 2'b10);
    add_vec(3'b111, 2'b10, 2'b11);
    add_vec(3'b000, 2'b10, 2'b11);
    add_vec(3'b011, 2'b10, 2'b11);
    add_vec(3'b000, 2'b10, 2'b11);
    add_vec(3'b000, 2'b10, 2'b01);
    add_vec(3'b000, 2'b10, 2'b10);

    rst = 1'b1;
    {ips_l, ips_c, ips_r} = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_hold", 2'b00, 2'b00);

    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].sens);
      checkOutput($sformatf("vec%0d_lcr%b", i, vecs[i].sens), vecs[i].exp_a, vecs[i].exp_b);
    end

    // Enter C90 with the crossover memory set, then reset mid-cycle.
    applyStimulus(3'b101);
    checkOutput("pre_rst_cross", 2'b10, 2'b10);
    applyStimulus(3'b111);
    checkOutput("pre_rst_c90", 2'b10, 2'b10);
    applyStimulus(3'b111);
    checkOutput("pre_rst_c90_hold", 2'b10, 2'b11);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset", 2'b00, 2'b00);
    @(posedge clk);
    #1;
    checkOutput("reset_held_1", 2'b00, 2'b00);
    @(posedge clk);
    #1;
    checkOutput("reset_held_2", 2'b00, 2'b00);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(3'b000);
    checkOutput("post_rst_edge1", 2'b00, 2'b00);
    applyStimulus(3'b000);
    checkOutput("post_rst_edge2", 2'b10, 2'b10);

    // A cleared crossover memory keeps a 101 crossing in CROSS, so 111 then turns 90.
    applyStimulus(3'b101);
    checkOutput("post_rst_cross", 2'b10, 2'b10);
    applyStimulus(3'b101);
    checkOutput("post_rst_cross_hold", 2'b10, 2'b10);
    applyStimulus(3'b111);
    checkOutput("post_rst_to_c90", 2'b10, 2'b10);
    applyStimulus(3'b000);
    checkOutput("post_rst_c90_drive", 2'b10, 2'b11);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
